oam_dma: RTL

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_pkg.sv | 27 ++
 rtl/oam_dma.sv | 111 +++++++++++
 2 files changed

// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared types and constants for the sprite-attribute DMA engine.
// Holds the DMA FSM state encoding, the PPU/OAM register map and the
// default trigger address and transfer length used by oam_dma.
package oam_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // PPU register map as seen on the CPU bus
  localparam logic [15:0] PPUCTRL_ADDR   = 16'h2000;
  localparam logic [15:0] PPUMASK_ADDR   = 16'h2001;
  localparam logic [15:0] PPUSTATUS_ADDR = 16'h2002;
  localparam logic [15:0] OAMADDR_ADDR   = 16'h2003;
  localparam logic [15:0] OAMDATA_ADDR   = 16'h2004;
  localparam logic [15:0] PPUSCROLL_ADDR = 16'h2005;
  localparam logic [15:0] PPUADDR_ADDR   = 16'h2006;
  localparam logic [15:0] PPUDATA_ADDR   = 16'h2007;
  localparam logic [15:0] OAMDMA_ADDR    = 16'h4014;

  localparam logic [15:0] DMA_REG_DEFAULT  = OAMDMA_ADDR;
  localparam int          XFER_LEN_DEFAULT = 256;

endpackage

// File: rtl/oam_dma.sv
// oam_dma: copies one 256-byte CPU page into sprite OAM while stalling the CPU.
// Ports: CLK/Reset (sync, active-high); cpu_w/cpu_addr/cpu_wdata CPU write port;
//   cpu_halt stall request; mem_r/mem_address/mem_rdata work-RAM read port
//   (1-cycle read latency); oam_w/oam_addr/oam_wdata OAM write port.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG  = DMA_REG_DEFAULT,
  parameter int          XFER_LEN = XFER_LEN_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        cpu_w,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_halt,
  output logic        mem_r,
  output logic [15:0] mem_address,
  input  logic [7:0]  mem_rdata,
  output logic        oam_w,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_e      state_q, state_d;
  logic        odd_q;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  page_q, page_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        trigger;

  assign trigger = cpu_w && (cpu_addr == DMA_REG);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    page_d     = page_q;
    mem_addr_d = mem_addr_q;
    oam_addr_d = oam_addr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        // writes arriving in any other state never reach this branch
        if (trigger) begin
          state_d = ST_ALIGN;
          page_d  = cpu_wdata;
          idx_d   = 8'd0;
        end
      end
      ST_ALIGN: begin
        // leave only when the following cycle is even (odd_q flips to 0),
        // so every READ lands on an even cycle
        if (odd_q) state_d = ST_READ;
      end
      ST_READ: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // keep the byte just written so oam_wdata holds it afterwards
        wdata_d = mem_rdata;
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = 8'd0;
        end else begin
          state_d = ST_READ;
          idx_d   = idx_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // address registers load on entry so they are stable for the whole
    // strobe cycle and hold their last value otherwise
    if (state_d == ST_READ)  mem_addr_d = {page_d, idx_d};
    if (state_d == ST_WRITE) oam_addr_d = idx_d;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      odd_q      <= 1'b0;
      idx_q      <= 8'd0;
      page_q     <= 8'd0;
      mem_addr_q <= 16'd0;
      oam_addr_q <= 8'd0;
      wdata_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      odd_q      <= ~odd_q;
      idx_q      <= idx_d;
      page_q     <= page_d;
      mem_addr_q <= mem_addr_d;
      oam_addr_q <= oam_addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign cpu_halt    = (state_q != ST_IDLE);
  assign mem_r       = (state_q == ST_READ);
  assign oam_w       = (state_q == ST_WRITE);
  assign mem_address = mem_addr_q;
  assign oam_addr    = oam_addr_q;
  // RAM data arrives during WRITE, so it is passed straight through
  assign oam_wdata   = oam_w ? mem_rdata : wdata_q;

endmodule
